// File: rtl/systolic_mmu.sv
// systolic_mmu: NxN weight-stationary systolic matrix-multiply unit with internal input skew and output deskew.
// Optional feature: define MMU_SAT_EN to saturate accumulator adds instead of wrapping modulo 2^AW.
module systolic_mmu #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_weight,
    input  logic [N*N*DW-1:0]    weights_in,
    output logic                 w_ready,
    input  logic                 a_valid,
    input  logic [N*DW-1:0]      a_in,
    output logic                 a_ready,
    output logic                 out_valid,
    output logic [N*AW-1:0]      out_row,
    output logic                 busy
);
    localparam int LAT = 2 * N;
    localparam int VL  = LAT - 1;
    localparam int CW  = $clog2(LAT + 1);

`ifdef MMU_SAT_EN
    localparam int AWX = AW + 1;

    function automatic logic signed [AW-1:0] addAcc(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        s = AWX'(a) + AWX'(b);
        if (s[AW] != s[AW-1])
            return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return s[AW-1:0];
    endfunction
`else
    function automatic logic signed [AW-1:0] addAcc(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
        return a + b;
    endfunction
`endif

    logic                         wLoaded_q;
    logic [CW-1:0]                inFlight_q, inFlight_d;
    logic [VL-1:0]                validPipe_q;
    logic                         outValid_q;
    logic [N*AW-1:0]              outRow_q;
    logic                         accept;
    logic                         loadWeights;
    logic [N-1:0][N-1:0][DW-1:0]  actTap;
    logic [N-1:0][N-1:0][AW-1:0]  sumBus;
    logic [N-1:0][AW-1:0]         colOut;

    assign a_ready     = wLoaded_q && !load_weight;
    assign accept      = a_valid && a_ready;
    assign w_ready     = (inFlight_q == '0);
    assign busy        = !w_ready;
    assign loadWeights = load_weight && w_ready;
    assign out_valid   = outValid_q;
    assign out_row     = outRow_q;

    // Lane r feeds column c after r+c cycles: the first r taps are the skew, the rest move activations right.
    for (genvar r = 0; r < N; r++) begin : gLane
        localparam int LEN = r + N - 1;
        if (LEN == 0) begin : gNoDelay
            assign actTap[r][0] = a_in[r*DW +: DW];
        end else begin : gDelay
            logic [DW-1:0] line_q [LEN];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < LEN; d++) line_q[d] <= '0;
                end else begin
                    line_q[0] <= a_in[r*DW +: DW];
                    for (int d = 1; d < LEN; d++) line_q[d] <= line_q[d-1];
                end
            end
            for (genvar c = 0; c < N; c++) begin : gTap
                if (r + c == 0) begin : gRaw
                    assign actTap[r][c] = a_in[r*DW +: DW];
                end else begin : gReg
                    assign actTap[r][c] = line_q[r+c-1];
                end
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : gRow
        for (genvar c = 0; c < N; c++) begin : gPe
            logic signed [DW-1:0]   weight_q;
            logic signed [AW-1:0]   acc_q, acc_d, psumIn;
            logic signed [2*DW-1:0] product;

            if (r == 0) begin : gTop
                assign psumIn = '0;
            end else begin : gBelow
                assign psumIn = sumBus[r-1][c];
            end

            assign product = $signed(actTap[r][c]) * weight_q;
            assign acc_d   = addAcc(psumIn, AW'(product));

            always_ff @(posedge clk) begin
                if (reset) begin
                    weight_q <= '0;
                    acc_q    <= '0;
                end else begin
                    if (loadWeights) weight_q <= weights_in[(r*N+c)*DW +: DW];
                    acc_q <= acc_d;
                end
            end

            assign sumBus[r][c] = acc_q;
        end
    end

    // Column c finishes N-1-c cycles before the last column; pad it so every column lands together.
    for (genvar c = 0; c < N; c++) begin : gDeskew
        localparam int D = N - 1 - c;
        if (D == 0) begin : gDirect
            assign colOut[c] = sumBus[N-1][c];
        end else begin : gPad
            logic [AW-1:0] line_q [D];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < D; d++) line_q[d] <= '0;
                end else begin
                    line_q[0] <= sumBus[N-1][c];
                    for (int d = 1; d < D; d++) line_q[d] <= line_q[d-1];
                end
            end
            assign colOut[c] = line_q[D-1];
        end
    end

    always_comb begin
        inFlight_d = inFlight_q;
        if (accept && !outValid_q)
            inFlight_d = inFlight_q + CW'(1);
        else if (!accept && outValid_q)
            inFlight_d = inFlight_q - CW'(1);
    end

    // With saturating PEs the bottom-row sum already lies inside the output clamp range.
    always_ff @(posedge clk) begin
        if (reset) begin
            wLoaded_q   <= 1'b0;
            inFlight_q  <= '0;
            validPipe_q <= '0;
            outValid_q  <= 1'b0;
            outRow_q    <= '0;
        end else begin
            if (loadWeights) wLoaded_q <= 1'b1;
            inFlight_q  <= inFlight_d;
            validPipe_q <= (validPipe_q << 1) | VL'(accept);
            outValid_q  <= validPipe_q[VL-1];
            if (validPipe_q[VL-1]) outRow_q <= colOut;
        end
    end
endmodule
